mem_port_arbiter: RTL

//  Shares the single external memory port between I-cache refill and D-cache

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between I-cache refill
// and D-cache refill/writeback requests. D-side has priority. The I-side is
// granted after at most STARVE_MAX consecutive D grants while it waits.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   ic_req_i/ic_addr_i                I-cache refill request and line address
//   ic_gnt_o/ic_done_o/ic_rdata_o     I grant pulse, done pulse, refill line
//   dc_req_i/dc_we_i/dc_addr_i/dc_wdata_i
//                                     D-cache request, write flag, address, data
//   dc_gnt_o/dc_done_o/dc_rdata_o     D grant pulse, done pulse, refill line
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o
//                                     memory request, held until mem_ready_i
//   mem_ready_i/mem_rdata_i           memory completion and read data
//   stall_core_o                      pipeline stall (combinational)
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_gnt_o,
  output logic              ic_done_o,
  output logic [LINE_W-1:0] ic_rdata_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_gnt_o,
  output logic              dc_done_o,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              stall_core_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_win_d, w_win_d_nxt;
  logic [CNT_W-1:0]    r_starve_cnt, w_starve_nxt;
  logic                r_ic_gnt, w_ic_gnt_nxt;
  logic                r_dc_gnt, w_dc_gnt_nxt;
  logic                r_ic_done, w_ic_done_nxt;
  logic                r_dc_done, w_dc_done_nxt;
  logic [LINE_W-1:0]   r_ic_rdata, w_ic_rdata_nxt;
  logic [LINE_W-1:0]   r_dc_rdata, w_dc_rdata_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [LINE_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic                w_i_starved;

  // I-side has waited through STARVE_MAX D grants: D must yield this round
  assign w_i_starved = ic_req_i && (r_starve_cnt == CNT_W'(STARVE_MAX));

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_win_d      <= 1'b0;
      r_starve_cnt <= '0;
      r_ic_gnt     <= 1'b0;
      r_dc_gnt     <= 1'b0;
      r_ic_done    <= 1'b0;
      r_dc_done    <= 1'b0;
      r_ic_rdata   <= '0;
      r_dc_rdata   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_win_d      <= w_win_d_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_ic_gnt     <= w_ic_gnt_nxt;
      r_dc_gnt     <= w_dc_gnt_nxt;
      r_ic_done    <= w_ic_done_nxt;
      r_dc_done    <= w_dc_done_nxt;
      r_ic_rdata   <= w_ic_rdata_nxt;
      r_dc_rdata   <= w_dc_rdata_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_win_d_nxt     = r_win_d;
    w_starve_nxt    = r_starve_cnt;
    w_ic_gnt_nxt    = 1'b0;
    w_dc_gnt_nxt    = 1'b0;
    w_ic_done_nxt   = 1'b0;
    w_dc_done_nxt   = 1'b0;
    w_ic_rdata_nxt  = r_ic_rdata;
    w_dc_rdata_nxt  = r_dc_rdata;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;

    unique case (r_state)
      ST_IDLE: begin
        if (dc_req_i && !w_i_starved) begin
          w_state_nxt     = ST_SERVE_D;
          w_win_d_nxt     = 1'b1;
          w_dc_gnt_nxt    = 1'b1;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = dc_we_i;
          w_mem_addr_nxt  = dc_addr_i;
          w_mem_wdata_nxt = dc_wdata_i;
          if (!ic_req_i)
            w_starve_nxt = '0;
          else if (r_starve_cnt != CNT_W'(STARVE_MAX))
            w_starve_nxt = r_starve_cnt + CNT_W'(1);
        end else if (ic_req_i) begin
          w_state_nxt    = ST_SERVE_I;
          w_win_d_nxt    = 1'b0;
          w_ic_gnt_nxt   = 1'b1;
          w_mem_req_nxt  = 1'b1;
          w_mem_we_nxt   = 1'b0;
          w_mem_addr_nxt = ic_addr_i;
          w_starve_nxt   = '0;
        end else begin
          w_starve_nxt = '0;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (mem_ready_i) begin
          w_state_nxt   = ST_RESP;
          w_mem_req_nxt = 1'b0;
          if (r_win_d) begin
            w_dc_done_nxt = 1'b1;
            // writebacks leave the refill line untouched
            if (!r_mem_we)
              w_dc_rdata_nxt = mem_rdata_i;
          end else begin
            w_ic_done_nxt  = 1'b1;
            w_ic_rdata_nxt = mem_rdata_i;
          end
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ic_gnt_o     = r_ic_gnt;
  assign dc_gnt_o     = r_dc_gnt;
  assign ic_done_o    = r_ic_done;
  assign dc_done_o    = r_dc_done;
  assign ic_rdata_o   = r_ic_rdata;
  assign dc_rdata_o   = r_dc_rdata;
  assign mem_req_o    = r_mem_req;
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;
  assign stall_core_o = (r_state != ST_IDLE) | ic_req_i | dc_req_i;

endmodule
